// File: rtl/calc_seq_ctrl.sv
// Calculator front end: keypad operand entry, memory write handshake, CPU launch,
// sequential double-dabble and 8-digit seven-segment display (bit0=a .. bit6=g).
// Optional macro SIGNED_RESULT_EN: treat the result as two's complement and show a '-' digit.
module calc_seq_ctrl #(
    parameter int                DATA_W      = 32,
    parameter int                DIGITS      = 2,
    parameter int                DISP_DIGITS = 4,
    parameter logic [DATA_W-1:0] OPA_ADDR    = DATA_W'(1),
    parameter logic [DATA_W-1:0] OP_ADDR     = DATA_W'(2),
    parameter logic [DATA_W-1:0] OPB_ADDR    = DATA_W'(3),
    parameter int                TIMEOUT     = 200
) (
    input  logic              hz100,
    input  logic              rst,
    input  logic [20:0]       pb,
    input  logic [DATA_W-1:0] ram_value,
    input  logic              cpu_done,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              mem_en,
    output logic              cpu_en,
    output logic [63:0]       ss
);
    localparam int BCD_CALC = (DATA_W * 31) / 100 + 1;
    localparam int BCD_N    = (BCD_CALC < 8) ? 8 : BCD_CALC;
    localparam int BI_W     = 4 * DIGITS;
    localparam int TW       = $clog2(TIMEOUT + 1);
    localparam int BW       = $clog2(DATA_W + 1);

    localparam logic [3:0] S_NUM1  = 4'd0;
    localparam logic [3:0] S_NUM2  = 4'd1;
    localparam logic [3:0] S_WR_A  = 4'd2;
    localparam logic [3:0] S_WR_OP = 4'd3;
    localparam logic [3:0] S_WR_B  = 4'd4;
    localparam logic [3:0] S_RUN   = 4'd5;
    localparam logic [3:0] S_CONV  = 4'd6;
    localparam logic [3:0] S_SHOW  = 4'd7;
    localparam logic [3:0] S_ERR   = 4'd8;

    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_R     = 8'h50;
    localparam logic [7:0] SEG_MINUS = 8'h40;
    localparam logic [7:0] SEG_0     = 8'h3F;

    logic [3:0]           r_state;
    logic [20:0]          r_pb_q;
    logic [DATA_W-1:0]    r_a, r_b, r_bin, r_addr, r_data;
    logic [2:0]           r_cnt;
    logic [BI_W-1:0]      r_bcd_in;
    logic [3:0]           r_op;
    logic [4*BCD_N-1:0]   r_bcd;
    logic [BW-1:0]        r_bitcnt;
    logic [TW-1:0]        r_timer;
    logic                 r_neg, r_mem_en, r_cpu_en;
    logic [63:0]          r_ss;

    logic [20:0]          w_press;
    logic                 w_onehot, w_key_digit, w_key_op, w_key_eq, w_key_clr;
    logic [3:0]           w_digit, w_d;
    logic [DATA_W-1:0]    w_cur, w_cur_next, w_mag;
    logic                 w_neg, w_ovf, w_seen;
    logic [4*BCD_N-1:0]   w_bcd_adj, w_bcd_shift;
    logic [27:0]          w_disp;
    logic [2:0]           w_msd;
    logic [63:0]          w_ss_next;

`ifdef SIGNED_RESULT_EN
    localparam int DISP_N = (DISP_DIGITS > 6) ? 6 : DISP_DIGITS;
    assign w_neg = ram_value[DATA_W-1];
    assign w_mag = w_neg ? (~ram_value + DATA_W'(1)) : ram_value;
`else
    localparam int DISP_N = DISP_DIGITS;
    assign w_neg = 1'b0;
    assign w_mag = ram_value;
`endif

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0: return 8'h3F;  4'd1: return 8'h06;  4'd2: return 8'h5B;
            4'd3: return 8'h4F;  4'd4: return 8'h66;  4'd5: return 8'h6D;
            4'd6: return 8'h7D;  4'd7: return 8'h07;  4'd8: return 8'h7F;
            4'd9: return 8'h6F;  default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] seg_op(input logic [3:0] op);
        case (op)
            4'b1000: return 8'h77;  4'b0100: return 8'h6D;
            4'b0010: return 8'h37;  4'b0001: return 8'h5E;
            default: return 8'h00;
        endcase
    endfunction

    assign w_press     = pb & ~r_pb_q;
    assign w_onehot    = (w_press != '0) && ((w_press & (w_press - 21'd1)) == '0);
    assign w_key_digit = w_onehot && (|w_press[9:0]);
    assign w_key_op    = w_onehot && (|w_press[19:16]);
    assign w_key_eq    = w_onehot && w_press[14];
    assign w_key_clr   = w_onehot && w_press[12];
    assign w_cur       = (r_state == S_NUM1) ? r_a : r_b;
    assign w_cur_next  = (w_cur << 3) + (w_cur << 1) + DATA_W'(w_digit);

    always_comb begin
        w_digit = '0;
        for (int unsigned i = 0; i < 10; i++)
            if (w_press[i]) w_digit = 4'(i);
    end

    // Double-dabble step: correct each BCD digit, then shift in the next binary MSB.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int unsigned i = 0; i < BCD_N; i++)
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        w_bcd_shift = {w_bcd_adj[4*BCD_N-2:0], r_bin[DATA_W-1]};
        w_ovf       = (w_bcd_shift >> (4 * DISP_N)) != '0;
    end

    always_comb begin
        w_ss_next = '0;
        w_disp    = '0;
        w_seen    = 1'b0;
        w_msd     = 3'd0;
        w_d       = '0;
        case (r_state)
            S_NUM1, S_NUM2: w_disp = 28'(r_bcd_in);
            S_SHOW:         w_disp = r_bcd[27:0];
            default:        w_disp = '0;
        endcase
        for (int unsigned k = 0; k < 7; k++) begin
            w_d = w_disp[4*(6-k) +: 4];
            if (!w_seen && (w_d != 4'd0 || k == 6)) begin
                w_seen = 1'b1;
                w_msd  = 3'(6 - k);
            end
            if (w_seen) w_ss_next[8*(6-k) +: 8] = seg_digit(w_d);
        end
        if (r_state == S_SHOW && r_neg && w_msd != 3'd6)
            w_ss_next[8*(int'(w_msd)+1) +: 8] = SEG_MINUS;
        if (r_state == S_NUM2) w_ss_next[63:56] = seg_op(r_op);
        if (r_state == S_ERR)  w_ss_next = {40'b0, SEG_E, SEG_R, SEG_R};
    end

    always_ff @(posedge hz100) begin
        r_pb_q <= pb;
        if (rst || w_key_clr) begin
            r_state  <= S_NUM1;
            r_a      <= '0;  r_b      <= '0;  r_bin  <= '0;
            r_addr   <= '0;  r_data   <= '0;  r_cnt  <= '0;
            r_bcd_in <= '0;  r_op     <= '0;  r_bcd  <= '0;
            r_bitcnt <= '0;  r_timer  <= '0;  r_neg  <= 1'b0;
            r_mem_en <= 1'b0; r_cpu_en <= 1'b0;
            r_ss     <= rst ? 64'd0 : {56'd0, SEG_0};
        end else begin
            if (r_state == S_NUM1 || r_state == S_NUM2 || r_state == S_SHOW || r_state == S_ERR)
                r_ss <= w_ss_next;
            case (r_state)
                S_NUM1, S_NUM2: begin
                    if (w_key_digit) begin
                        if (r_cnt < 3'(DIGITS)) begin
                            if (r_state == S_NUM1) r_a <= w_cur_next;
                            else                   r_b <= w_cur_next;
                            r_bcd_in <= (r_bcd_in << 4) | BI_W'(w_digit);
                            r_cnt    <= r_cnt + 3'd1;
                        end
                    end else if (w_key_op) begin
                        if (r_state == S_NUM1 && r_cnt != 3'd0) begin
                            r_op     <= w_press[19:16];
                            r_state  <= S_NUM2;
                            r_cnt    <= '0;
                            r_bcd_in <= '0;
                        end else if (r_state == S_NUM2 && r_cnt == 3'd0) begin
                            r_op <= w_press[19:16];
                        end
                    end else if (w_key_eq && r_state == S_NUM2 && r_cnt != 3'd0) begin
                        r_state <= (r_op == 4'b0001 && r_b == '0) ? S_ERR : S_WR_A;
                    end
                end
                // mem_en is raised only from a low cycle, which guarantees the gap between writes.
                S_WR_A, S_WR_OP, S_WR_B: begin
                    if (!r_mem_en) begin
                        r_mem_en <= 1'b1;
                        if (r_state == S_WR_A) begin
                            r_addr <= OPA_ADDR;  r_data <= r_a;
                        end else if (r_state == S_WR_OP) begin
                            r_addr <= OP_ADDR;   r_data <= DATA_W'(r_op);
                        end else begin
                            r_addr <= OPB_ADDR;  r_data <= r_b;
                        end
                    end else if (mem_ack) begin
                        r_mem_en <= 1'b0;
                        if (r_state == S_WR_A)       r_state <= S_WR_OP;
                        else if (r_state == S_WR_OP) r_state <= S_WR_B;
                        else begin
                            r_state  <= S_RUN;
                            r_cpu_en <= 1'b1;
                            r_timer  <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (cpu_done) begin
                        r_cpu_en <= 1'b0;
                        r_bin    <= w_mag;
                        r_neg    <= w_neg;
                        r_bcd    <= '0;
                        r_bitcnt <= '0;
                        r_state  <= S_CONV;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        r_cpu_en <= 1'b0;
                        r_state  <= S_ERR;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_CONV: begin
                    r_bcd    <= w_bcd_shift;
                    r_bin    <= r_bin << 1;
                    r_bitcnt <= r_bitcnt + BW'(1);
                    if (r_bitcnt == BW'(DATA_W - 1))
                        r_state <= w_ovf ? S_ERR : S_SHOW;
                end
                S_SHOW, S_ERR: begin
                    if (w_key_digit) begin
                        r_state  <= S_NUM1;
                        r_a      <= DATA_W'(w_digit);
                        r_b      <= '0;
                        r_bcd_in <= BI_W'(w_digit);
                        r_cnt    <= 3'd1;
                        r_op     <= '0;
                        r_neg    <= 1'b0;
                    end
                end
                default: r_state <= S_NUM1;
            endcase
        end
    end

    assign addr_out = r_addr;
    assign data_out = r_data;
    assign mem_en   = r_mem_en;
    assign cpu_en   = r_cpu_en;
    assign ss       = r_ss;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl: key-entry vector table plus write/run/convert/timeout/clear sequences.
module tb_calc_seq_ctrl;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 200;

    localparam logic [7:0] G0 = 8'h3F, G1 = 8'h06, G2 = 8'h5B, G3 = 8'h4F, G4 = 8'h66;
    localparam logic [7:0] G5 = 8'h6D, G6 = 8'h7D, G7 = 8'h07, G9 = 8'h6F;
    localparam logic [7:0] GA = 8'h77, GS = 8'h6D, GE = 8'h79, GR = 8'h50, GMIN = 8'h40;
    localparam logic [63:0] ERRSS = {40'b0, GE, GR, GR};

    localparam int K_ADD = 19, K_SUB = 18, K_MUL = 17, K_DIV = 16, K_EQ = 14, K_CLR = 12;

    logic              hz100 = 1'b0;
    logic              rst = 1'b1;
    logic [20:0]       pb = '0;
    logic [DATA_W-1:0] ram_value = '0;
    logic              cpu_done = 1'b0;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] addr_out, data_out;
    logic              mem_en, cpu_en;
    logic [63:0]       ss;

    calc_seq_ctrl #(.DATA_W(DATA_W), .DIGITS(2), .DISP_DIGITS(4), .TIMEOUT(TIMEOUT)) dut (
        .hz100(hz100), .rst(rst), .pb(pb), .ram_value(ram_value), .cpu_done(cpu_done),
        .mem_ack(mem_ack), .addr_out(addr_out), .data_out(data_out), .mem_en(mem_en),
        .cpu_en(cpu_en), .ss(ss)
    );

    always #5 hz100 = ~hz100;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [20:0] key(input int k);
        logic [20:0] one;
        one = 21'd1;
        return one << k;
    endfunction

    task automatic press_pat(input logic [20:0] p);
        @(negedge hz100); pb = p;
        @(negedge hz100); pb = '0;
        @(negedge hz100);
    endtask

    // Memory model: acknowledges each request two cycles after mem_en, up to ack_limit writes.
    int                ack_limit = 1000;
    int                n_writes  = 0;
    int                mem_rise  = 0;
    int                wait_cnt  = 0;
    logic              mem_en_q  = 1'b0;
    logic              cpu_en_at_ack = 1'b0;
    logic [DATA_W-1:0] wr_addr[$];
    logic [DATA_W-1:0] wr_data[$];

    initial forever begin
        @(negedge hz100);
        if (mem_en && !mem_en_q) mem_rise++;
        mem_en_q = mem_en;
        if (mem_ack) mem_ack = 1'b0;
        else if (mem_en && n_writes < ack_limit) begin
            if (wait_cnt == 1) begin
                mem_ack = 1'b1;
                wr_addr.push_back(addr_out);
                wr_data.push_back(data_out);
                cpu_en_at_ack = cpu_en;
                n_writes++;
                wait_cnt = 0;
            end else wait_cnt++;
        end else wait_cnt = 0;
    end

    typedef struct packed {
        logic [20:0] pat;
        logic [63:0] exp_ss;
    } vec_t;
    vec_t vecs[15];

    task automatic wait_cpu_en(input string name);
        int cyc;
        cyc = 0;
        while (!cpu_en && cyc < 100) begin @(negedge hz100); cyc++; end
        check(name, 64'(cpu_en), 64'd1);
    endtask

    initial begin
        int r0, hi;
        logic [DATA_W-1:0] exp_a[3], exp_d[3];

        vecs[0]  = '{key(1),           {56'b0, G1}};
        vecs[1]  = '{key(2),           {48'b0, G1, G2}};
        vecs[2]  = '{key(3),           {48'b0, G1, G2}};
        vecs[3]  = '{key(K_ADD),       {GA, 48'b0, G0}};
        vecs[4]  = '{key(K_SUB),       {GS, 48'b0, G0}};
        vecs[5]  = '{key(0),           {GS, 48'b0, G0}};
        vecs[6]  = '{key(K_MUL),       {GS, 48'b0, G0}};
        vecs[7]  = '{key(5),           {GS, 48'b0, G5}};
        vecs[8]  = '{key(9),           {GS, 48'b0, G5}};
        vecs[9]  = '{key(1) | key(2),  {GS, 48'b0, G5}};
        vecs[10] = '{key(K_CLR),       {56'b0, G0}};
        vecs[11] = '{key(K_EQ),        {56'b0, G0}};
        vecs[12] = '{key(K_ADD),       {56'b0, G0}};
        vecs[13] = '{key(0),           {56'b0, G0}};
        vecs[14] = '{key(7),           {56'b0, G7}};

        repeat (3) @(negedge hz100);
        check("rst_ss", ss, 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_cpu_en", 64'(cpu_en), 64'd0);
        check("rst_addr", 64'(addr_out), 64'd0);
        check("rst_data", 64'(data_out), 64'd0);
        rst = 1'b0;
        @(negedge hz100);

        for (int unsigned i = 0; i < 15; i++) begin
            press_pat(vecs[i].pat);
            check($sformatf("vec%0d", i), ss, vecs[i].exp_ss);
        end

        // Divide by zero: no writes, straight to ERR; ERR ignores operators, restarts on a digit.
        press_pat(key(K_CLR));
        press_pat(key(5)); press_pat(key(K_DIV)); press_pat(key(0));
        r0 = mem_rise;
        press_pat(key(K_EQ));
        repeat (5) @(negedge hz100);
        check("div0_no_write", 64'(mem_rise - r0), 64'd0);
        check("div0_err", ss, ERRSS);
        press_pat(key(K_ADD));
        check("err_op_ignored", ss, ERRSS);
        press_pat(key(3));
        check("err_digit_restart", ss, {56'b0, G3});

        // 42 + 7: write order, cpu_en after third ack, result latency.
        press_pat(key(K_CLR));
        wr_addr.delete(); wr_data.delete(); n_writes = 0;
        press_pat(key(4)); press_pat(key(2)); press_pat(key(K_ADD)); press_pat(key(7));
        check("entry_b7", ss, {GA, 48'b0, G7});
        press_pat(key(K_EQ));
        wait_cpu_en("cpu_en_rise");
        check("write_count", 64'(n_writes), 64'd3);
        check("cpu_en_low_at_ack3", 64'(cpu_en_at_ack), 64'd0);
        exp_a = '{32'd1, 32'd2, 32'd3};
        exp_d = '{32'd42, 32'd8, 32'd7};
        for (int unsigned i = 0; i < 3 && i < wr_addr.size(); i++) begin
            check($sformatf("wr%0d_addr", i), 64'(wr_addr[i]), 64'(exp_a[i]));
            check($sformatf("wr%0d_data", i), 64'(wr_data[i]), 64'(exp_d[i]));
        end
        repeat (3) @(negedge hz100);
        ram_value = 32'd49; cpu_done = 1'b1;
        @(posedge hz100);
        @(negedge hz100);
        cpu_done = 1'b0; ram_value = '0;
        repeat (DATA_W) @(posedge hz100);
        #1 check("result_held", ss, {GA, 48'b0, G7});
        @(posedge hz100);
        #1 check("result_49", ss, {48'b0, G4, G9});
        check("cpu_en_off", 64'(cpu_en), 64'd0);

        // 3 - 9 with a two's-complement result word.
        press_pat(key(3)); press_pat(key(K_SUB)); press_pat(key(9));
        wr_data.delete(); wr_addr.delete(); n_writes = 0;
        press_pat(key(K_EQ));
        wait_cpu_en("cpu_en_rise_sub");
        check("sub_op_code", 64'(wr_data.size() > 1 ? wr_data[1] : '1), 64'd4);
        @(negedge hz100);
        ram_value = 32'hFFFF_FFFA; cpu_done = 1'b1;
        @(negedge hz100);
        cpu_done = 1'b0;
        repeat (DATA_W + 3) @(negedge hz100);
`ifdef SIGNED_RESULT_EN
        check("signed_result", ss, {48'b0, GMIN, G6});
`else
        check("unsigned_overflow", ss, ERRSS);
`endif

        // Timeout: cpu_en high exactly TIMEOUT cycles, then Err.
        press_pat(key(K_CLR));
        press_pat(key(1)); press_pat(key(K_ADD)); press_pat(key(1)); press_pat(key(K_EQ));
        wait_cpu_en("cpu_en_rise_to");
        hi = 0;
        while (cpu_en && hi < TIMEOUT + 50) begin @(negedge hz100); hi++; end
        check("timeout_cycles", 64'(hi), 64'(TIMEOUT));
        @(negedge hz100);
        check("timeout_err", ss, ERRSS);

        // Clear while WR_OP waits for an ack that never comes.
        press_pat(key(K_CLR));
        press_pat(key(6)); press_pat(key(K_ADD)); press_pat(key(2));
        wr_addr.delete(); wr_data.delete(); n_writes = 0; ack_limit = 1;
        press_pat(key(K_EQ));
        hi = 0;
        while (!(mem_en && addr_out == 32'd2) && hi < 100) begin @(negedge hz100); hi++; end
        check("wrop_addr", 64'(addr_out), 64'd2);
        check("wrop_data", 64'(data_out), 64'd8);
        repeat (3) @(negedge hz100);
        check("wrop_held", 64'(mem_en), 64'd1);
        pb = key(K_CLR);
        @(negedge hz100);
        pb = '0;
        check("clr_mem_en", 64'(mem_en), 64'd0);
        check("clr_ss", ss, {56'b0, G0});
        ack_limit = 1000;
        cpu_done = 1'b1;
        @(negedge hz100);
        cpu_done = 1'b0;
        repeat (2) @(negedge hz100);
        check("done_ignored_num1", ss, {56'b0, G0});
        check("cpu_en_idle", 64'(cpu_en), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
